alu_result_stage: RTL and testbench

Registered result stage directly downstream of the 8-bit ALU. It accepts the ALU's result and flags with the instruction's destination tag, and updates the architectural Zero/LT flag register. It buffers up to two results in a skid FIFO ahead of register-file writeback, and exposes a forwarding lookup so the operand stage can bypass results that have not yet been written back.

---
 rtl/alu_result_stage.sv | 113 +++++++++++
 tb/tb_alu_result_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Result stage behind the 8-bit ALU: architectural Zero/LT flags, a 2-entry
// skid buffer ahead of register-file writeback, and a forwarding lookup.
module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int AW    = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [DW-1:0] AluOut,
  input  logic          AluZero,
  input  logic          AluLT,
  input  logic [AW-1:0] InDest,
  input  logic          InWrEn,
  input  logic          InSetFlags,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [DW-1:0] WrData,
  output logic [AW-1:0] WrAddr,
  output logic          WrEn,
  output logic          ZeroFlag,
  output logic          LTFlag,
  input  logic [AW-1:0] FwdAddr,
  output logic          FwdHit,
  output logic [DW-1:0] FwdData
);

  logic [DW-1:0] r_data [DEPTH];
  logic [AW-1:0] r_dest [DEPTH];
  logic          r_wren [DEPTH];
  logic          r_wrp;
  logic          r_rdp;
  logic [1:0]    r_count;
  logic          r_zero;
  logic          r_lt;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_yng;
  logic          w_yng_hit;
  logic          w_old_hit;

  assign w_full  = (r_count == 2'(DEPTH));
  assign w_empty = (r_count == 2'd0);
  assign w_push  = InValid & ~w_full;
  assign w_pop   = ~w_empty & OutReady;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_dest[0] <= '0;
      r_dest[1] <= '0;
      r_wren[0] <= 1'b0;
      r_wren[1] <= 1'b0;
      r_wrp     <= 1'b0;
      r_rdp     <= 1'b0;
      r_count   <= '0;
      r_zero    <= 1'b0;
      r_lt      <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[r_wrp] <= AluOut;
        r_dest[r_wrp] <= InDest;
        r_wren[r_wrp] <= InWrEn;
        r_wrp         <= ~r_wrp;
        if (InSetFlags) begin
          r_zero <= AluZero;
          r_lt   <= AluLT;
        end
      end
      if (w_pop) begin
        r_rdp <= ~r_rdp;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign InReady  = ~w_full;
  assign OutValid = ~w_empty;
  assign WrData   = r_data[r_rdp];
  assign WrAddr   = r_dest[r_rdp];
  assign WrEn     = ~w_empty & r_wren[r_rdp];
  assign ZeroFlag = r_zero;
  assign LTFlag   = r_lt;

  // Youngest entry sits just behind the write pointer; with one entry it is
  // also the head, so the older slot only counts when the buffer is full.
  assign w_yng     = ~r_wrp;
  assign w_yng_hit = ~w_empty & r_wren[w_yng] & (r_dest[w_yng] == FwdAddr);
  assign w_old_hit = w_full   & r_wren[r_rdp] & (r_dest[r_rdp] == FwdAddr);

  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    if (w_yng_hit) begin
      FwdHit  = 1'b1;
      FwdData = r_data[w_yng];
    end else if (w_old_hit) begin
      FwdHit  = 1'b1;
      FwdData = r_data[r_rdp];
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed checks of alu_result_stage against a queue model.
module tb_alu_result_stage;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       InValid;
  logic       InReady;
  logic [7:0] AluOut;
  logic       AluZero;
  logic       AluLT;
  logic [2:0] InDest;
  logic       InWrEn;
  logic       InSetFlags;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] WrData;
  logic [2:0] WrAddr;
  logic       WrEn;
  logic       ZeroFlag;
  logic       LTFlag;
  logic [2:0] FwdAddr;
  logic       FwdHit;
  logic [7:0] FwdData;

  alu_result_stage #(.DEPTH(2), .DW(8), .AW(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .AluOut(AluOut), .AluZero(AluZero), .AluLT(AluLT),
    .InDest(InDest), .InWrEn(InWrEn), .InSetFlags(InSetFlags),
    .OutValid(OutValid), .OutReady(OutReady),
    .WrData(WrData), .WrAddr(WrAddr), .WrEn(WrEn),
    .ZeroFlag(ZeroFlag), .LTFlag(LTFlag),
    .FwdAddr(FwdAddr), .FwdHit(FwdHit), .FwdData(FwdData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    bit         w;
  } ent_t;

  ent_t q[$];
  bit   m_zero;
  bit   m_lt;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_zero = 1'b0;
    m_lt   = 1'b0;
  endtask

  task automatic check_model();
    bit         hit;
    logic [7:0] fd;
    hit = 1'b0;
    fd  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && q[i].w && q[i].a == FwdAddr) begin
        hit = 1'b1;
        fd  = q[i].d;
      end
    end
    chk("in_ready",  InReady,  q.size() < 2);
    chk("out_valid", OutValid, q.size() != 0);
    if (q.size() != 0) begin
      chk("wr_data", WrData, q[0].d);
      chk("wr_addr", WrAddr, q[0].a);
      chk("wr_en",   WrEn,   q[0].w);
    end else begin
      chk("wr_en_idle", WrEn, 1'b0);
    end
    chk("zero_flag", ZeroFlag, m_zero);
    chk("lt_flag",   LTFlag,   m_lt);
    chk("fwd_hit",   FwdHit,   hit);
    chk("fwd_data",  FwdData,  fd);
  endtask

  // One clock: drive at negedge, compare against the model, then advance it.
  task automatic cycle(input bit v, input logic [7:0] d, input logic [2:0] dst,
                       input bit we, input bit z, input bit lt, input bit sf,
                       input bit ordy, input logic [2:0] fa);
    bit push;
    bit pop;
    @(negedge Clk);
    InValid = v; AluOut = d; InDest = dst; InWrEn = we;
    AluZero = z; AluLT = lt; InSetFlags = sf; OutReady = ordy; FwdAddr = fa;
    #1;
    check_model();
    @(posedge Clk);
    push = v && (q.size() < 2);
    pop  = ordy && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back('{d: d, a: dst, w: we});
      if (sf) begin
        m_zero = z;
        m_lt   = lt;
      end
    end
  endtask

  initial begin
    Reset = 1'b0; InValid = 1'b1; AluOut = 8'h99; InDest = 3'd1; InWrEn = 1'b1;
    AluZero = 1'b1; AluLT = 1'b1; InSetFlags = 1'b1; OutReady = 1'b0; FwdAddr = 3'd1;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_out_valid", OutValid, 1'b0);
    chk("rst_in_ready",  InReady,  1'b1);
    chk("rst_zero",      ZeroFlag, 1'b0);
    chk("rst_lt",        LTFlag,   1'b0);
    chk("rst_wr_en",     WrEn,     1'b0);
    chk("rst_wr_data",   WrData,   8'h00);
    chk("rst_wr_addr",   WrAddr,   3'd0);
    chk("rst_fwd_hit",   FwdHit,   1'b0);
    chk("rst_fwd_data",  FwdData,  8'h00);
    @(negedge Clk);
    InValid = 1'b0;
    Reset   = 1'b1;

    // First result straight through
    cycle(1, 8'h2A, 3'd3, 1, 0, 0, 0, 0, 3'd3);
    #1;
    chk("first_data", WrData, 8'h2A);
    chk("first_addr", WrAddr, 3'd3);
    chk("first_wren", WrEn,   1'b1);
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd0);

    // Fill with OutReady low, third push refused, then drain in order
    cycle(1, 8'h05, 3'd1, 1, 0, 0, 0, 0, 3'd1);
    cycle(1, 8'h07, 3'd2, 1, 0, 0, 0, 0, 3'd1);
    #1;
    chk("full_in_ready", InReady, 1'b0);
    cycle(1, 8'h09, 3'd5, 1, 0, 0, 0, 0, 3'd5);
    #1;
    chk("held_head", WrData, 8'h05);
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd0);
    #1;
    chk("drain_second", WrData, 8'h07);
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd0);
    #1;
    chk("drained_valid", OutValid, 1'b0);
    chk("drained_ready", InReady,  1'b1);

    // Flags follow pushes that request them only
    cycle(1, 8'h00, 3'd1, 0, 1, 0, 1, 1, 3'd0);
    cycle(1, 8'h10, 3'd1, 0, 0, 1, 0, 1, 3'd0);
    #1;
    chk("flag_zero_held", ZeroFlag, 1'b1);
    chk("flag_lt_held",   LTFlag,   1'b0);
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd0);

    // Forwarding picks the younger of two matches
    cycle(1, 8'h11, 3'd2, 1, 0, 0, 0, 0, 3'd2);
    cycle(1, 8'h22, 3'd2, 1, 0, 0, 0, 0, 3'd2);
    #1;
    FwdAddr = 3'd2;
    #1;
    chk("fwd_young_hit",  FwdHit,  1'b1);
    chk("fwd_young_data", FwdData, 8'h22);
    FwdAddr = 3'd4;
    #1;
    chk("fwd_miss_hit",  FwdHit,  1'b0);
    chk("fwd_miss_data", FwdData, 8'h00);
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd2);
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd2);

    // Wrap-around values streamed, then reset mid-stream
    cycle(1, 8'hFF, 3'd6, 1, 0, 1, 1, 1, 3'd6);
    cycle(1, 8'h00, 3'd6, 1, 1, 0, 1, 1, 3'd6);
    #1;
    chk("wrap_ff", WrData, 8'h00);
    cycle(1, 8'h01, 3'd7, 1, 0, 0, 1, 1, 3'd7);
    #1;
    chk("wrap_01", WrData, 8'h01);
    #2;
    Reset = 1'b0;
    #1;
    chk("midrst_valid", OutValid, 1'b0);
    chk("midrst_wren",  WrEn,     1'b0);
    chk("midrst_fwd",   FwdHit,   1'b0);
    model_reset();
    @(negedge Clk);
    InValid = 1'b0;
    Reset   = 1'b1;
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd7);
    cycle(0, 8'h00, 3'd0, 0, 0, 0, 0, 1, 3'd7);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, 3'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
